// File: rtl/i2s_sample_serializer.sv
`timescale 1ns/1ps
// Drains the sample ring buffer at one pull per stereo frame and emits mono-duplicated I2S (MSB first, one-bit LRCLK delay).
// Free-running timing that never stalls on the buffer; define I2S_UNDERRUN_HOLD_EN to repeat the last sample on underrun instead of muting.
module i2s_sample_serializer #(
    parameter int WIDTH    = 16,
    parameter int BCLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_read,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             underrun
);
    localparam int DW    = $clog2(BCLK_DIV);
    localparam int SLOTS = 2 * WIDTH;
    localparam int BW    = $clog2(SLOTS);

    localparam logic [DW-1:0] DIV_LAST    = DW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] SLOT_LAST   = BW'(SLOTS - 1);
    localparam logic [BW-1:0] SLOT_RIGHT  = BW'(WIDTH);
    localparam logic [BW-1:0] LR_HI_FIRST = BW'(WIDTH - 1);

    logic [DW-1:0]    r_div_cnt;
    logic [BW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_sample;
    logic [WIDTH-1:0] r_shift;
    logic             r_cap;

    logic             w_tick;
    logic             w_rise;
    logic             w_fall;
    logic             w_decide;
    logic             w_reload;
    logic [BW-1:0]    w_bit_nxt;
    logic [WIDTH-1:0] w_sample_nxt;

    assign w_tick    = (r_div_cnt == DIV_LAST);
    assign w_rise    = w_tick & ~bclk;
    assign w_fall    = w_tick & bclk;
    assign w_decide  = w_rise & (r_bit_cnt == SLOT_LAST);
    assign w_bit_nxt = (r_bit_cnt == SLOT_LAST) ? '0 : r_bit_cnt + BW'(1);
    assign w_reload  = (w_bit_nxt == '0) || (w_bit_nxt == SLOT_RIGHT);

    // Forwarding the captured word lets slot 0 load it even when capture and the falling edge coincide (BCLK_DIV=2).
    always_comb begin
        w_sample_nxt = r_sample;
        if (r_cap) begin
            w_sample_nxt = fifo_data;
        end else if (underrun) begin
`ifdef I2S_UNDERRUN_HOLD_EN
            w_sample_nxt = r_sample;
`else
            w_sample_nxt = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_bit_cnt <= SLOT_LAST;
            r_sample  <= '0;
            r_shift   <= '0;
            r_cap     <= 1'b0;
            bclk      <= 1'b0;
            lrclk     <= 1'b0;
            sdata     <= 1'b0;
            fifo_read <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DW'(1);
            r_cap     <= fifo_read;
            r_sample  <= w_sample_nxt;
            fifo_read <= w_decide & ~fifo_empty;
            underrun  <= w_decide & fifo_empty;
            if (w_tick) begin
                bclk <= ~bclk;
            end
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                lrclk     <= (w_bit_nxt >= LR_HI_FIRST) && (w_bit_nxt != SLOT_LAST);
                // Each channel restarts from the full sample so the right slot repeats the left.
                if (w_reload) begin
                    r_shift <= w_sample_nxt;
                    sdata   <= w_sample_nxt[WIDTH-1];
                end else begin
                    r_shift <= r_shift << 1;
                    sdata   <= r_shift[WIDTH-2];
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_sample_serializer.sv
`timescale 1ns/1ps
// Bench for i2s_sample_serializer: DUT A at defaults (16-bit, div 4) and DUT B at 8-bit, div 2, each fed by a ring-buffer model.
module tb_i2s_sample_serializer;
    localparam int WA = 16;
    localparam int DA = 4;
    localparam int WB = 8;
    localparam int DB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // index 0 = DUT A, index 1 = DUT B
    logic [1:0] rst   = 2'b11;
    logic [1:0] rst_d = 2'b11;
    logic [1:0] f_empty, f_read, bclk, lrclk, sdata, und;
    logic [WA-1:0] f_data_a = '0;
    logic [WB-1:0] f_data_b = '0;

    logic [15:0] mem_a [0:15];
    logic [15:0] mem_b [0:15];
    int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;

    logic [15:0] expq_a [$];
    logic [15:0] expq_b [$];
    int exp_fetch [2];
    int exp_und   [2];

    int n_vec  = 0;
    int n_fail = 0;
    logic end_req = 1'b0;
    logic end_ack = 1'b0;

    assign f_empty = {(wr_b == rd_b), (wr_a == rd_a)};

    i2s_sample_serializer #(.WIDTH(WA), .BCLK_DIV(DA)) u_dut_a (
        .clk(clk), .rst(rst[0]), .fifo_empty(f_empty[0]), .fifo_data(f_data_a),
        .fifo_read(f_read[0]), .bclk(bclk[0]), .lrclk(lrclk[0]), .sdata(sdata[0]), .underrun(und[0])
    );

    i2s_sample_serializer #(.WIDTH(WB), .BCLK_DIV(DB)) u_dut_b (
        .clk(clk), .rst(rst[1]), .fifo_empty(f_empty[1]), .fifo_data(f_data_b),
        .fifo_read(f_read[1]), .bclk(bclk[1]), .lrclk(lrclk[1]), .sdata(sdata[1]), .underrun(und[1])
    );

    // Ring buffer model: data_out is registered, valid the clk after a read request.
    always @(posedge clk) begin
        rst_d <= rst;
        if (f_read[0] && (wr_a != rd_a)) begin
            f_data_a <= mem_a[rd_a];
            rd_a     <= rd_a + 1;
        end
        if (f_read[1] && (wr_b != rd_b)) begin
            f_data_b <= mem_b[rd_b][WB-1:0];
            rd_b     <= rd_b + 1;
        end
    end

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h, required 0x%0h", name, idx, got, want);
        end
    endtask

    task automatic push_a(input logic [15:0] v);
        mem_a[wr_a] = v;
        wr_a++;
    endtask

    task automatic push_b(input logic [15:0] v);
        mem_b[wr_b] = v;
        wr_b++;
    endtask

    // Monitor / scoreboard state
    int          slot     [2];
    int          rel      [2];
    int          last_rel [2];
    int          nfetch   [2] = '{0, 0};
    int          nund     [2] = '{0, 0};
    logic        prev_b   [2];
    logic        started  [2];
    logic        held_sd  [2];
    logic        have_dec [2];
    logic        in_rst   [2] = '{1'b0, 1'b0};
    logic [15:0] lword    [2];
    logic [15:0] rword    [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int          w, nsl, dv;
            logic        rise, fall, have_exp;
            logic [15:0] exp_w;
            w   = (i == 0) ? WA : WB;
            dv  = (i == 0) ? DA : DB;
            nsl = 2 * w;
            if (rst_d[i]) begin
                if (!in_rst[i])
                    check("reset_outputs", i, {27'd0, bclk[i], lrclk[i], sdata[i], f_read[i], und[i]}, 32'd0);
                in_rst[i]   = 1'b1;
                slot[i]     = nsl - 1;
                started[i]  = 1'b0;
                prev_b[i]   = 1'b0;
                have_dec[i] = 1'b0;
                rel[i]      = 0;
                lword[i]    = '0;
                rword[i]    = '0;
            end else begin
                in_rst[i] = 1'b0;
                rel[i]++;
                rise = bclk[i] & ~prev_b[i];
                fall = ~bclk[i] & prev_b[i];
                if (fall) begin
                    slot[i] = (slot[i] + 1) % nsl;
                    if (slot[i] == 0) started[i] = 1'b1;
                end
                if (rise) begin
                    held_sd[i] = sdata[i];
                    check("lrclk_slot", i, {31'd0, lrclk[i]},
                          {31'd0, (slot[i] >= w - 1) && (slot[i] <= nsl - 2)});
                    if (slot[i] < w) lword[i][w - 1 - slot[i]] = sdata[i];
                    else             rword[i][w - 1 - (slot[i] - w)] = sdata[i];
                    if (slot[i] == nsl - 1 && started[i]) begin
                        have_exp = 1'b0;
                        exp_w    = '0;
                        if (i == 0 && expq_a.size() > 0) begin exp_w = expq_a.pop_front(); have_exp = 1'b1; end
                        if (i == 1 && expq_b.size() > 0) begin exp_w = expq_b.pop_front(); have_exp = 1'b1; end
                        check("frame_expected", i, {31'd0, have_exp}, 32'd1);
                        if (have_exp) begin
                            check("left_word", i, {16'd0, lword[i]}, {16'd0, exp_w});
                            check("right_word", i, {16'd0, rword[i]}, {16'd0, exp_w});
                        end
                    end
                end else if (bclk[i]) begin
                    check("sdata_stable", i, {31'd0, sdata[i]}, {31'd0, held_sd[i]});
                end
                if (f_read[i] || und[i]) begin
                    check("fetch_xor_underrun", i, {31'd0, f_read[i] & und[i]}, 32'd0);
                    check("decision_on_rise_slot_last", i, {31'd0, rise && (slot[i] == nsl - 1)}, 32'd1);
                    if (!have_dec[i]) check("first_fetch_delay", i, rel[i], dv);
                    else              check("fetch_period", i, rel[i] - last_rel[i], 4 * w * dv);
                    have_dec[i] = 1'b1;
                    last_rel[i] = rel[i];
                    if (f_read[i]) nfetch[i]++;
                    if (und[i])    nund[i]++;
                end
                if (f_read[i]) check("read_while_empty", i, {31'd0, f_empty[i]}, 32'd0);
                prev_b[i] = bclk[i];
            end
        end
        if (end_req && !end_ack) begin
            for (int i = 0; i < 2; i++) begin
                check("fetch_count", i, nfetch[i], exp_fetch[i]);
                check("underrun_count", i, nund[i], exp_und[i]);
            end
            check("frames_missing", 0, expq_a.size(), 0);
            check("frames_missing", 1, expq_b.size(), 0);
            end_ack = 1'b1;
        end
    end

    initial begin
        // DUT B: two samples, then the buffer runs dry for two decisions.
        push_b(16'h005A);
        push_b(16'h0081);
        expq_b.push_back(16'h005A);
        expq_b.push_back(16'h0081);
`ifdef I2S_UNDERRUN_HOLD_EN
        expq_b.push_back(16'h0081);
`else
        expq_b.push_back(16'h0000);
`endif
        exp_fetch[1] = 2;
        exp_und[1]   = 2;
        repeat (3) @(posedge clk);
        #2 rst[1] = 1'b0;
        repeat (200) @(posedge clk);
        #2 rst[1] = 1'b1;

        // DUT A: back-to-back samples, an underrun, recovery, then a reset inside slot 10.
        push_a(16'hA5C3);
        push_a(16'h0001);
        push_a(16'h8000);
        push_a(16'hFFFF);
        expq_a.push_back(16'hA5C3);
        expq_a.push_back(16'h0001);
        expq_a.push_back(16'h8000);
        expq_a.push_back(16'hFFFF);
`ifdef I2S_UNDERRUN_HOLD_EN
        expq_a.push_back(16'hFFFF);
`else
        expq_a.push_back(16'h0000);
`endif
        expq_a.push_back(16'h1234);
        expq_a.push_back(16'h7E81);
        exp_fetch[0] = 7;
        exp_und[0]   = 2;
        repeat (3) @(posedge clk);
        #2 rst[0] = 1'b0;
        repeat (1100) @(posedge clk);
        #2 push_a(16'h1234);
        repeat (300) @(posedge clk);
        #2 push_a(16'hBEEF);
        // Frame carrying 0xBEEF is aborted by the reset; its slot 10 spans edges 1624..1631.
        repeat (226) @(posedge clk);
        #2 rst[0] = 1'b1;
        push_a(16'h7E81);
        @(posedge clk);
        #2 rst[0] = 1'b0;
        repeat (270) @(posedge clk);
        #2 rst[0] = 1'b1;

        repeat (2) @(posedge clk);
        #2 end_req = 1'b1;
        for (int k = 0; k < 10 && !end_ack; k++) @(posedge clk);
        if (!end_ack) begin
            $display("FAIL end_handshake: got no ack, required ack");
            $fatal(1, "monitor did not respond");
        end
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_sample_serializer.md
Name: i2s_sample_serializer

Overview:
- Downstream consumer of the sample ring buffer. It pops one sample per stereo frame and serialises it as a standard I2S stream (BCLK, LRCLK, SDATA) to the external DAC.
- The synth is mono, so the same sample goes out on the left and right slots.
- This block generates the pull that drains the buffer at the audio sample rate.

Parameters:
- WIDTH, 16, bits per sample; must match the buffer's WIDTH.
- BCLK_DIV, 4, clk cycles per BCLK half-period; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- fifo_empty  input  1  empty flag from the ring buffer.
- fifo_data  input  WIDTH  ring buffer data_out; valid on the clk after a read request.
- fifo_read  output  1  ring buffer read_enable; single-cycle pulse.
- bclk  output  1  I2S bit clock, period 2*BCLK_DIV clk.
- lrclk  output  1  I2S word select; 0 = left, 1 = right.
- sdata  output  1  I2S serial data, MSB first.
- underrun  output  1  one-cycle pulse when a fetch finds the buffer empty.

Behaviour:
- Reset: all outputs are registered.
  - bclk=0, lrclk=0, sdata=0, fifo_read=0, underrun=0.
  - div_cnt=0, bit_cnt=2*WIDTH-1, sample register=0, shift register=0.
  - Reset mid-frame aborts the frame. Any in-flight fetch is discarded and the sequence restarts exactly as after power-up.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - When div_cnt==BCLK_DIV-1, bclk toggles on the next edge.
  - The first rising BCLK edge occurs BCLK_DIV clk after reset release.
- Slots:
  - bit_cnt is in 0..2*WIDTH-1 and advances modulo 2*WIDTH on every bclk 1->0 transition.
  - Slots 0..WIDTH-1 carry the left channel; slots WIDTH..2*WIDTH-1 carry the right channel.
- LRCLK (I2S one-bit delay):
  - lrclk=1 for slots WIDTH-1..2*WIDTH-2; lrclk=0 for slot 2*WIDTH-1 and slots 0..WIDTH-2.
  - lrclk changes together with the bclk falling edge.
- SDATA:
  - Updated only on bclk 1->0 transitions; stable for the whole high phase.
  - Slot k (0..WIDTH-1) carries sample bit WIDTH-1-k.
  - Slot WIDTH+k repeats that same bit.
- Fetch:
  - Decision cycle: the cycle in which bclk becomes 1 while bit_cnt==2*WIDTH-1.
  - If fifo_empty==0, fifo_read=1 for that cycle only. fifo_data is captured into the sample register one clk later.
  - If fifo_empty==1, fifo_read stays 0, underrun=1 for that cycle, and the sample register is loaded with 0.
  - On the following bclk falling edge (start of slot 0), the sample register is loaded into the shift register.
- Rates: exactly one fetch per frame. Frame length = 4*WIDTH*BCLK_DIV clk (256 at the defaults).
- Write side: never back-pressures or stalls. Pacing is free-running; buffer state does not alter timing.
- fifo_read is never asserted while fifo_empty is 1 in the same cycle.

Optional Feature:
- Macro: I2S_UNDERRUN_HOLD_EN.
- Defined: on underrun, the sample register keeps its previous value, so the last sample is repeated. The underrun pulse still fires.
- Undefined: on underrun the sample register is cleared, giving a silent frame.
- Timing, ports and the fifo_read rule are identical in both builds.

Test Plan:
- Reset release, buffer non-empty, defaults -> fifo_read is a one-clk pulse in the same cycle bclk first goes 1 (4th clk after rst drops); next pulse exactly 256 clk later.
- Buffer supplies 0xA5C3 -> slots 0..15 sdata = 1010010111000011; slots 16..31 repeat it; lrclk low in slots 31, 0..14 and high in slots 15..30.
- Buffer empty at the decision cycle -> fifo_read stays 0, underrun pulses for 1 clk, and the next frame is all zeros. With I2S_UNDERRUN_HOLD_EN, the next frame repeats the previous sample (e.g. 0xA5C3 again).
- Samples 0x0001, 0x8000, 0xFFFF written back-to-back -> three consecutive frames carry them in order; no extra or missing fifo_read pulses; underrun never fires.
- rst asserted for 1 clk during slot 10 -> outputs reach reset values on the next clk; after release the first fetch again occurs 4 clk later and a fresh frame starts at slot 0.
- BCLK_DIV=2, WIDTH=8 -> BCLK period is 4 clk; frame is 64 clk; the sample is captured and shifted out correctly with minimum capture margin.
